// File: rtl/eggtimer_ctrl.sv
// ============================================================================
// Module   : eggtimer_ctrl
// Brief    : Egg-timer countdown controller (BCD MM:SS edit, 1 Hz countdown,
//            flashing alarm with auto-timeout).
// Revision : 1.0
// ============================================================================
`default_nettype none

module eggtimer_ctrl #(
    parameter logic [15:0] DEFAULT_TIME = 16'h0300,
    parameter int unsigned ALARM_SECS   = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       display_on,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);

    state_t      state_q, state_d;
    logic [15:0] time_q, time_d;
    logic [15:0] preset_q, preset_d;
    logic [7:0]  acnt_q, acnt_d;
    logic        disp_q, disp_d;
    logic        running_q, running_d;
    logic        alarm_q, alarm_d;
    logic [15:0] dec_t;

    function automatic logic [15:0] inc_min(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mu;
        mt = t[15:12];
        mu = t[11:8];
        if (mu == 4'd9) begin
            mu = 4'd0;
            mt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
        end else begin
            mu = mu + 4'd1;
        end
        return {mt, mu, t[7:0]};
    endfunction

    function automatic logic [15:0] inc_sec(input logic [15:0] t);
        logic [3:0] st;
        logic [3:0] su;
        st = t[7:4];
        su = t[3:0];
        if (su == 4'd9) begin
            su = 4'd0;
            st = (st == 4'd5) ? 4'd0 : st + 4'd1;
        end else begin
            su = su + 4'd1;
        end
        return {t[15:8], st, su};
    endfunction

    // Borrow ripples sec units -> sec tens -> min units -> min tens.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [3:0] mt;
        logic [3:0] mu;
        logic [3:0] st;
        logic [3:0] su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        preset_d = preset_q;
        acnt_d   = acnt_q;
        disp_d   = 1'b1;
        dec_t    = dec_time(time_q);

        case (state_q)
            ST_IDLE: begin
                if (btn_clear) begin
                    time_d = DEFAULT_TIME;
                end else if (btn_start && (time_q != 16'h0000)) begin
                    preset_d = time_q;
                    state_d  = ST_RUN;
                end else begin
                    if (btn_min) time_d = inc_min(time_d);
                    if (btn_sec) time_d = inc_sec(time_d);
                end
            end
            ST_RUN: begin
                if (btn_clear) begin
                    time_d  = preset_q;
                    state_d = ST_IDLE;
                end else if (tick_1hz && ((time_q == 16'h0000) || (dec_t == 16'h0000))) begin
                    // Reaching zero wins over a simultaneous pause request.
                    time_d  = 16'h0000;
                    state_d = ST_ALARM;
                    acnt_d  = ALARM_LOAD;
                end else begin
                    if (tick_1hz) time_d = dec_t;
                    if (btn_start) state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    time_d  = preset_q;
                    state_d = ST_IDLE;
                end else if (btn_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                time_d = 16'h0000;
                disp_d = disp_q;
                if (btn_clear || btn_start || (tick_1hz && (acnt_q <= 8'd1))) begin
                    time_d  = preset_q;
                    state_d = ST_IDLE;
                    acnt_d  = 8'd0;
                    disp_d  = 1'b1;
                end else if (tick_1hz) begin
                    acnt_d = acnt_q - 8'd1;
                    disp_d = ~disp_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                time_d  = DEFAULT_TIME;
                acnt_d  = 8'd0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            time_q    <= DEFAULT_TIME;
            preset_q  <= DEFAULT_TIME;
            acnt_q    <= 8'd0;
            disp_q    <= 1'b1;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            preset_q  <= preset_d;
            acnt_q    <= acnt_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign digit3     = time_q[15:12];
    assign digit2     = time_q[11:8];
    assign digit1     = time_q[7:4];
    assign digit0     = time_q[3:0];
    assign display_on = disp_q;
    assign running    = running_q;
    assign alarm      = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_eggtimer_ctrl.sv
// ============================================================================
// Module   : tb_eggtimer_ctrl
// Brief    : Scoreboard bench for eggtimer_ctrl (default and short-alarm DUTs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_eggtimer_ctrl;

    typedef struct {
        int          sel;
        logic [15:0] t;
        logic        d;
        logic        r;
        logic        a;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tick = '0, bstart = '0, bclear = '0, bmin = '0, bsec = '0;
    logic [3:0] d0 [2];
    logic [3:0] d1 [2];
    logic [3:0] d2 [2];
    logic [3:0] d3 [2];
    logic [1:0] disp, run, alm;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_mm, exp_ss;

    always #5 clk = ~clk;

    eggtimer_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick[0]), .btn_start(bstart[0]),
        .btn_clear(bclear[0]), .btn_min(bmin[0]), .btn_sec(bsec[0]),
        .digit0(d0[0]), .digit1(d1[0]), .digit2(d2[0]), .digit3(d3[0]),
        .display_on(disp[0]), .running(run[0]), .alarm(alm[0])
    );

    eggtimer_ctrl #(.ALARM_SECS(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick[1]), .btn_start(bstart[1]),
        .btn_clear(bclear[1]), .btn_min(bmin[1]), .btn_sec(bsec[1]),
        .digit0(d0[1]), .digit1(d1[1]), .digit2(d2[1]), .digit3(d3[1]),
        .display_on(disp[1]), .running(run[1]), .alarm(alm[1])
    );

    function automatic logic [15:0] bcd(input int mm, input int ss);
        logic [3:0] a, b, c, e;
        a = 4'(mm / 10);
        b = 4'(mm % 10);
        c = 4'(ss / 10);
        e = 4'(ss % 10);
        return {a, b, c, e};
    endfunction

    // Monitor: one expectation is consumed per clock after the edge it describes.
    initial begin
        exp_t e;
        logic [15:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {d3[e.sel], d2[e.sel], d1[e.sel], d0[e.sel]};
                checks++;
                if (act !== e.t || disp[e.sel] !== e.d || run[e.sel] !== e.r || alm[e.sel] !== e.a) begin
                    failures++;
                    $display("FAIL %s dut%0d: got time=%h disp=%b run=%b alarm=%b, want time=%h disp=%b run=%b alarm=%b",
                             e.nm, e.sel, act, disp[e.sel], run[e.sel], alm[e.sel], e.t, e.d, e.r, e.a);
                end
            end
        end
    end

    task automatic cyc(input int sel, input logic tk, input logic st, input logic cl,
                       input logic mn, input logic sc, input logic [15:0] et,
                       input logic ed, input logic er, input logic ea, input string nm);
        exp_t e;
        @(negedge clk);
        tick = '0; bstart = '0; bclear = '0; bmin = '0; bsec = '0;
        tick[sel] = tk; bstart[sel] = st; bclear[sel] = cl; bmin[sel] = mn; bsec[sel] = sc;
        e.sel = sel; e.t = et; e.d = ed; e.r = er; e.a = ea; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic hold_min(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            exp_mm = (exp_mm + 1) % 100;
            cyc(sel, 0, 0, 0, 1, 0, bcd(exp_mm, exp_ss), 1, 0, 0, "edit_min");
        end
    endtask

    task automatic hold_sec(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ss = (exp_ss + 1) % 60;
            cyc(sel, 0, 0, 0, 0, 1, bcd(exp_mm, exp_ss), 1, 0, 0, "edit_sec");
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = '0; bstart = '0; bclear = '0; bmin = '0; bsec = '0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        // Reset state and default countdown
        cyc(0, 0, 0, 0, 0, 0, 16'h0300, 1, 0, 0, "reset");
        cyc(0, 0, 1, 0, 0, 0, 16'h0300, 1, 1, 0, "start");
        cyc(0, 1, 0, 0, 0, 0, 16'h0259, 1, 1, 0, "tick1");
        cyc(0, 1, 0, 0, 0, 0, 16'h0258, 1, 1, 0, "tick2");
        cyc(0, 1, 0, 0, 0, 0, 16'h0257, 1, 1, 0, "tick3");
        cyc(0, 0, 0, 1, 0, 0, 16'h0300, 1, 0, 0, "clear_run");

        // BCD edit wrap
        exp_mm = 3; exp_ss = 0;
        hold_min(0, 97);
        hold_sec(0, 58);
        cyc(0, 0, 0, 0, 0, 1, 16'h0059, 1, 0, 0, "sec_59");
        cyc(0, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 0, "sec_wrap");
        exp_mm = 0; exp_ss = 0;
        hold_min(0, 99);
        cyc(0, 0, 0, 0, 0, 0, 16'h9900, 1, 0, 0, "min_99");
        cyc(0, 0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, "min_wrap");
        cyc(0, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 0, "start_zero");
        cyc(0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, "still_idle");
        cyc(0, 0, 0, 0, 1, 1, 16'h0101, 1, 0, 0, "both_edits");
        cyc(0, 1, 0, 0, 0, 0, 16'h0101, 1, 0, 0, "idle_tick");

        // Borrow chain
        cyc(0, 0, 0, 1, 0, 0, 16'h0300, 1, 0, 0, "clear_idle");
        exp_mm = 3; exp_ss = 0;
        hold_min(0, 7);
        cyc(0, 0, 1, 0, 0, 0, 16'h1000, 1, 1, 0, "start_10");
        cyc(0, 1, 0, 0, 0, 0, 16'h0959, 1, 1, 0, "borrow_10");
        cyc(0, 0, 0, 1, 0, 0, 16'h1000, 1, 0, 0, "clear_preset");
        exp_mm = 10; exp_ss = 0;
        hold_min(0, 91);
        cyc(0, 0, 1, 0, 0, 0, 16'h0100, 1, 1, 0, "start_01");
        cyc(0, 1, 0, 0, 0, 0, 16'h0059, 1, 1, 0, "borrow_01");
        cyc(0, 0, 0, 0, 1, 1, 16'h0059, 1, 1, 0, "run_edit");
        cyc(0, 0, 0, 1, 0, 0, 16'h0100, 1, 0, 0, "clear_01");

        // Pause with simultaneous start+tick, then clear
        exp_mm = 1; exp_ss = 0;
        hold_min(0, 99);
        hold_sec(0, 5);
        cyc(0, 0, 1, 0, 0, 0, 16'h0005, 1, 1, 0, "start_05");
        cyc(0, 1, 1, 0, 0, 0, 16'h0004, 1, 0, 0, "pause_tick");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 16'h0004, 1, 0, 0, "pause_hold");
        cyc(0, 0, 0, 0, 1, 0, 16'h0004, 1, 0, 0, "pause_edit");
        cyc(0, 0, 1, 0, 0, 0, 16'h0004, 1, 1, 0, "resume");
        cyc(0, 0, 0, 1, 0, 0, 16'h0005, 1, 0, 0, "clear_pause");

        // Alarm entry and flash
        exp_mm = 0; exp_ss = 5;
        hold_sec(0, 57);
        cyc(0, 0, 1, 0, 0, 0, 16'h0002, 1, 1, 0, "start_02");
        cyc(0, 1, 0, 0, 0, 0, 16'h0001, 1, 1, 0, "tick_01");
        cyc(0, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 1, "alarm_entry");
        cyc(0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, "alarm_hold");
        cyc(0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, "flash_0");
        cyc(0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 1, "alarm_edit");
        cyc(0, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, "flash_1");
        cyc(0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, "flash_2");
        cyc(0, 0, 0, 1, 0, 0, 16'h0002, 1, 0, 0, "alarm_clear");

        // Reset mid-RUN restores defaults including preset
        cyc(0, 0, 1, 0, 0, 0, 16'h0002, 1, 1, 0, "start_again");
        cyc(0, 1, 0, 0, 0, 0, 16'h0001, 1, 1, 0, "tick_again");
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 16'h0300, 1, 0, 0, "reset_run");
        cyc(0, 1, 0, 0, 0, 0, 16'h0300, 1, 0, 0, "reset_idle_tick");

        // Alarm timeout on the short-alarm instance
        exp_mm = 3; exp_ss = 0;
        hold_min(1, 97);
        hold_sec(1, 1);
        cyc(1, 0, 1, 0, 0, 0, 16'h0001, 1, 1, 0, "b_start");
        cyc(1, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, "b_entry");
        cyc(1, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, "b_tick1");
        cyc(1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 1, "b_edit_min");
        cyc(1, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1, "b_edit_sec");
        cyc(1, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, "b_tick2");
        cyc(1, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, "b_before");
        cyc(1, 1, 0, 0, 0, 0, 16'h0001, 1, 0, 0, "b_timeout");

        // Reset mid-ALARM
        cyc(1, 0, 1, 0, 0, 0, 16'h0001, 1, 1, 0, "b_start2");
        cyc(1, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, "b_entry2");
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 16'h0300, 1, 0, 0, "b_reset_alarm");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/eggtimer_ctrl.md
# eggtimer_ctrl

Countdown controller for the egg timer. Holds an MM:SS time in four BCD digits, edits it from debounced button pulses, counts down on a 1 Hz enable, and raises a flashing alarm at 00:00. Its four digit outputs and `display_on` feed the four-digit multiplexed seven-segment driver directly; it is the only block that sequences what that driver shows.

## Interface
Parameters:
- `DEFAULT_TIME`, 16'h0300, power-up and clear value as packed BCD {min tens, min units, sec tens, sec units}; must be a legal BCD time (min 00–99, sec 00–59).
- `ALARM_SECS`, 30, number of `tick_1hz` pulses the alarm lasts before it returns to IDLE on its own; range 1–255.

Ports:
- `clk` in 1: system clock; the single clock for the block.
- `rst_n` in 1: reset, asynchronous and active-low.
- `tick_1hz` in 1: single-cycle enable, once per second.
- `btn_start` in 1: single-cycle pulse (debounced upstream), start/pause toggle.
- `btn_clear` in 1: single-cycle pulse, clear/acknowledge.
- `btn_min` in 1: single-cycle pulse, +1 minute (IDLE only).
- `btn_sec` in 1: single-cycle pulse, +1 second (IDLE only).
- `digit0` out 4: seconds units, BCD.
- `digit1` out 4: seconds tens, BCD.
- `digit2` out 4: minutes units, BCD.
- `digit3` out 4: minutes tens, BCD.
- `display_on` out 1: 1 = show digits, 0 = blank (downstream gates the anodes).
- `running` out 1: 1 in RUN.
- `alarm` out 1: 1 in ALARM.

## Operation
- State machine with four states: IDLE, RUN, PAUSE, ALARM. A 16-bit `time` register drives the digits. A 16-bit `preset` register holds the last time that was started.
- Priority within a cycle, from highest to lowest: `btn_clear`, then tick processing, then `btn_start`, then edits.
- IDLE:
  - `btn_min`: minutes +1 in BCD, wrapping 99→00. Seconds are unchanged.
  - `btn_sec`: seconds +1 in BCD, wrapping 59→00, with no carry into minutes.
  - Both in the same cycle: both are applied.
  - `btn_start` with a nonzero time: `preset`←`time`, then go to RUN. With time 00:00 it is ignored.
  - `btn_clear`: `time`←`DEFAULT_TIME`. `preset` is unchanged.
  - `tick_1hz` is ignored.
- RUN:
  - `tick_1hz`: BCD decrement of the time.
    - sec units 0→9 with a borrow.
    - sec tens 0→5 with a borrow.
    - min units 0→9 with a borrow.
    - min tens −1.
  - If the decremented result is 00:00, go to ALARM on the same edge. This overrides a simultaneous `btn_start`.
  - Otherwise `btn_start` goes to PAUSE, and a tick in the same cycle is still applied.
  - `btn_clear`: `time`←`preset`, go to IDLE.
  - Edit buttons are ignored.
- PAUSE:
  - Ticks and edits are ignored.
  - `btn_start` goes to RUN.
  - `btn_clear`: `time`←`preset`, go to IDLE.
- ALARM:
  - `alarm`=1 and `time` holds at 00:00.
  - `display_on` toggles on every `tick_1hz`.
  - An 8-bit counter, loaded to `ALARM_SECS` on entry, decrements on each tick. When it reaches 0: `time`←`preset`, go to IDLE.
  - `btn_start` or `btn_clear`: `time`←`preset`, go to IDLE immediately.
  - Edits are ignored.
- `display_on`=1 in every state except while it is toggling in ALARM. It is forced to 1 on any exit from ALARM.
- The encoding is illegal-state safe: any unreachable state returns to IDLE with `time`←`DEFAULT_TIME`.

## Timing
- All outputs are registered.
- An input sampled high at rising edge N is reflected on the outputs after edge N. Latency is 1 cycle and there is no pipelining.
- Reset (asynchronous assert, synchronous release by the system):
  - state IDLE.
  - `time`=`preset`=`DEFAULT_TIME`, so digits read 0,0,3,0 for the default.
  - `running`=0, `alarm`=0, `display_on`=1.
  - alarm counter = 0.
- Reset mid-RUN or mid-ALARM aborts immediately to the reset values. No partial count survives.
- In RUN, entry to ALARM happens on the edge of the tick that produces 00:00. On that edge `alarm`=1, `running`=0 and `display_on`=1. The first blank occurs on the next tick.
- From ALARM entry, auto-return occurs exactly `ALARM_SECS` ticks later.
- Pulses are assumed to be single-cycle. A level held for k cycles in IDLE edits k times (no internal edge detection).

## Test plan
- **Reset and default:** assert `rst_n`=0 mid-cycle, then release. Required: digits 0,0,3,0; `display_on`=1; `running`=0; `alarm`=0; `btn_start` followed by 3 ticks gives 02:57.
- **BCD edit wrap:** in IDLE, set 00:58 and pulse `btn_sec` twice. Required: 00:59 then 00:00, minutes unchanged. Set 99:00 and pulse `btn_min`. Required: 00:00. Pulse `btn_start` at 00:00. Required: stays IDLE.
- **Borrow chain:** start at 10:00 and apply 1 tick. Required: 09:59. Continue from 01:00 with 1 tick. Required: 00:59.
- **Pause, simultaneous events and clear:** start at 00:05. Assert `btn_start` and `tick_1hz` on the same cycle. Required: 00:04 and PAUSE. Send 3 ticks. Required: still 00:04. Pulse `btn_start`, then `btn_clear`. Required: IDLE, 00:05.
- **Alarm entry and flash:** start at 00:02 with `btn_start` held together with the second tick. Required: ALARM on that edge, `alarm`=1, `display_on`=1. Next ticks give `display_on` 0,1,0. `btn_clear` gives IDLE at 00:02 with `display_on`=1.
- **Alarm timeout:** with `ALARM_SECS`=3, reach ALARM. Required: `alarm` drops exactly on the 3rd tick after entry, digits show the preset, and edits during ALARM have no effect.
